// File: rtl/router_output_allocator.sv
// Per-output-port switch allocator: round-robin arbitration, wormhole lock
// from head to tail flit, and downstream credit tracking.
module router_output_allocator #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_BUFFER_DEPTH = 1,
    parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
    parameter int IDX_WIDTH         = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                    clk_noc,
    input  logic                    rst_n,
    input  logic [NUM_INPUTS-1:0]   req,
    input  logic [NUM_INPUTS-1:0]   is_tail_in,
    input  logic [NUM_INPUTS-1:0]   disable_in,
    input  logic                    credit_in,
    output logic [NUM_INPUTS-1:0]   grant,
    output logic [IDX_WIDTH-1:0]    grant_idx,
    output logic                    send_out,
    output logic                    is_tail_out,
    output logic                    locked,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    err_credit_overflow
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0]    LAST_IDX   = IDX_WIDTH'(NUM_INPUTS - 1);
    localparam logic [CREDIT_WIDTH-1:0] MAX_CREDIT = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    state_t                  r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_WIDTH-1:0]    r_owner, w_owner_nxt;
    logic [CREDIT_WIDTH-1:0] r_credit, w_credit_nxt;
    logic                    r_err, w_err_nxt;

    logic [NUM_INPUTS-1:0]   w_eligible;
    logic                    w_has_credit;
    logic                    w_found;
    logic [IDX_WIDTH-1:0]    w_winner;
    logic [IDX_WIDTH-1:0]    w_scan;

    function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_WIDTH'(1);
    endfunction

    assign w_eligible   = req & ~disable_in;
    assign w_has_credit = (r_credit != '0);

    // First eligible input at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = r_rr_ptr;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!w_found && w_eligible[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
            w_scan = wrap_inc(w_scan);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        grant        = '0;
        grant_idx    = '0;
        send_out     = 1'b0;
        is_tail_out  = 1'b0;
        // Outputs are held quiet while reset is asserted, even with requests pending.
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_has_credit && w_found) begin
                        grant[w_winner] = 1'b1;
                        grant_idx       = w_winner;
                        send_out        = 1'b1;
                        is_tail_out     = is_tail_in[w_winner];
                        if (is_tail_in[w_winner]) begin
                            w_rr_ptr_nxt = wrap_inc(w_winner);
                        end else begin
                            w_state_nxt = ST_LOCKED;
                            w_owner_nxt = w_winner;
                        end
                    end
                end
                ST_LOCKED: begin
                    // The owner keeps the port mid-packet regardless of disable_in.
                    if (w_has_credit && req[r_owner]) begin
                        grant[r_owner] = 1'b1;
                        grant_idx      = r_owner;
                        send_out       = 1'b1;
                        is_tail_out    = is_tail_in[r_owner];
                        if (is_tail_in[r_owner]) begin
                            w_state_nxt  = ST_IDLE;
                            w_rr_ptr_nxt = wrap_inc(r_owner);
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_credit_nxt = r_credit;
        w_err_nxt    = r_err;
        if (credit_in && !send_out) begin
            if (r_credit == MAX_CREDIT) begin
                w_err_nxt = 1'b1;
            end else begin
                w_credit_nxt = r_credit + CREDIT_WIDTH'(1);
            end
        end else if (!credit_in && send_out) begin
            w_credit_nxt = r_credit - CREDIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_credit <= MAX_CREDIT;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_credit <= w_credit_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign locked              = (r_state == ST_LOCKED);
    assign credit_count        = r_credit;
    assign err_credit_overflow = r_err;

endmodule
